// File: rtl/ps2_keys_pkg.sv
// PS/2 set-2 key map, prefix bytes and decoder state shared by the
// key tracker and its consumers.
package ps2_keys_pkg;

  localparam logic [7:0] KEY_0         = 8'd0;
  localparam logic [7:0] KEY_1         = 8'd1;
  localparam logic [7:0] KEY_2         = 8'd2;
  localparam logic [7:0] KEY_3         = 8'd3;
  localparam logic [7:0] KEY_4         = 8'd4;
  localparam logic [7:0] KEY_5         = 8'd5;
  localparam logic [7:0] KEY_6         = 8'd6;
  localparam logic [7:0] KEY_7         = 8'd7;
  localparam logic [7:0] KEY_8         = 8'd8;
  localparam logic [7:0] KEY_9         = 8'd9;
  localparam logic [7:0] KEY_TILDE     = 8'd10;
  localparam logic [7:0] KEY_MINUS     = 8'd11;
  localparam logic [7:0] KEY_EQUALS    = 8'd12;
  localparam logic [7:0] KEY_BACKSPACE = 8'd13;
  localparam logic [7:0] KEY_TAB       = 8'd14;
  localparam logic [7:0] KEY_Q         = 8'd15;
  localparam logic [7:0] KEY_W         = 8'd16;
  localparam logic [7:0] KEY_E         = 8'd17;
  localparam logic [7:0] KEY_R         = 8'd18;
  localparam logic [7:0] KEY_T         = 8'd19;
  localparam logic [7:0] KEY_Y         = 8'd20;
  localparam logic [7:0] KEY_U         = 8'd21;
  localparam logic [7:0] KEY_I         = 8'd22;
  localparam logic [7:0] KEY_O         = 8'd23;
  localparam logic [7:0] KEY_P         = 8'd24;
  localparam logic [7:0] KEY_LBRACKET  = 8'd25;
  localparam logic [7:0] KEY_RBRACKET  = 8'd26;
  localparam logic [7:0] KEY_BACKSLASH = 8'd27;
  localparam logic [7:0] KEY_SPACE     = 8'd28;
  localparam logic [7:0] KEY_ENTER     = 8'd29;
  localparam logic [7:0] KEY_NONE      = 8'hFF;

  localparam logic [7:0] PFX_BREAK = 8'hF0;
  localparam logic [7:0] PFX_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } decState_e;

  function automatic logic [7:0] keyLookup(
    input logic [7:0] code,
    input logic       ext
  );
    logic [7:0] idx;
    idx = KEY_NONE;
    if (!ext) begin
      case (code)
        8'h45: idx = KEY_0;
        8'h16: idx = KEY_1;
        8'h1E: idx = KEY_2;
        8'h26: idx = KEY_3;
        8'h25: idx = KEY_4;
        8'h2E: idx = KEY_5;
        8'h36: idx = KEY_6;
        8'h3D: idx = KEY_7;
        8'h3E: idx = KEY_8;
        8'h46: idx = KEY_9;
        8'h0E: idx = KEY_TILDE;
        8'h4E: idx = KEY_MINUS;
        8'h55: idx = KEY_EQUALS;
        8'h66: idx = KEY_BACKSPACE;
        8'h0D: idx = KEY_TAB;
        8'h15: idx = KEY_Q;
        8'h1D: idx = KEY_W;
        8'h24: idx = KEY_E;
        8'h2D: idx = KEY_R;
        8'h2C: idx = KEY_T;
        8'h35: idx = KEY_Y;
        8'h3C: idx = KEY_U;
        8'h43: idx = KEY_I;
        8'h44: idx = KEY_O;
        8'h4D: idx = KEY_P;
        8'h54: idx = KEY_LBRACKET;
        8'h5B: idx = KEY_RBRACKET;
        8'h5D: idx = KEY_BACKSLASH;
        8'h29: idx = KEY_SPACE;
        8'h5A: idx = KEY_ENTER;
        default: idx = KEY_NONE;
      endcase
    end
    return idx;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO for key events; a pop frees a slot
// for a push in the same cycle even when full.
module ps2_evt_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] headData,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  logic         doPush;
  logic         doPop;

  assign empty = (wrPtr == rdPtr);
  assign full = (wrPtr[AW-1:0] == rdPtr[AW-1:0])
             && (wrPtr[AW] != rdPtr[AW]);
  assign doPop = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign headData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr[AW-1:0]] <= pushData;
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 make/break decoder with per-key held state and a
// buffered press/release event stream.
module ps2_key_tracker
  import ps2_keys_pkg::*;
#(
  parameter int NUM_KEYS       = 30,
  parameter int EVT_DEPTH      = 8,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        clear,
  output logic [NUM_KEYS-1:0]         key_state,
  output logic                        evt_valid,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic                        evt_pressed,
  input  logic                        evt_ready,
  output logic                        evt_overflow,
  output logic                        unknown_code
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [7:0] NK = 8'(NUM_KEYS);
  localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

  decState_e     state;
  logic [TW-1:0] toCnt;
  logic [7:0]    idx;
  logic          isBrk;
  logic          isExt;
  logic          doLookup;
  logic          known;
  logic          held;
  logic          push;
  logic          pop;
  logic          fifoEmpty;
  logic          fifoFull;
  logic [KW:0]   head;
  logic          isPfx;
  logic          isIgn;

  assign isPfx = (rx_data == PFX_BREAK) || (rx_data == PFX_EXT);
  assign isIgn = (rx_data == 8'hAA) || (rx_data == 8'hFA)
              || (rx_data == 8'hFE) || (rx_data == 8'hEE)
              || (rx_data == 8'h00) || (rx_data == 8'hFF);

  always_comb begin
    doLookup = 1'b0;
    isBrk = 1'b0;
    isExt = 1'b0;
    if (rx_valid && !clear && !isPfx) begin
      case (state)
        ST_IDLE:   doLookup = !isIgn;
        ST_BREAK: begin
          doLookup = 1'b1;
          isBrk = 1'b1;
        end
        ST_EXT: begin
          doLookup = 1'b1;
          isExt = 1'b1;
        end
        default: begin
          doLookup = 1'b1;
          isBrk = 1'b1;
          isExt = 1'b1;
        end
      endcase
    end
  end

  assign idx = keyLookup(rx_data, isExt);
  assign known = (idx < NK);
  assign held = key_state[idx[KW-1:0]];
  assign push = doLookup && known && (isBrk ? held : !held);
  assign pop = evt_valid && evt_ready;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      toCnt <= '0;
      key_state <= '0;
      unknown_code <= 1'b0;
      evt_overflow <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      toCnt <= '0;
      key_state <= '0;
      unknown_code <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      unknown_code <= doLookup && !known;
      if (push) key_state[idx[KW-1:0]] <= !isBrk;
      if (push && fifoFull && !pop) evt_overflow <= 1'b1;
      if (rx_valid) begin
        toCnt <= '0;
        case (state)
          ST_IDLE: begin
            if (rx_data == PFX_BREAK) state <= ST_BREAK;
            else if (rx_data == PFX_EXT) state <= ST_EXT;
          end
          ST_BREAK: begin
            if (rx_data == PFX_EXT) state <= ST_EXT;
            else if (rx_data != PFX_BREAK) state <= ST_IDLE;
          end
          ST_EXT: begin
            if (rx_data == PFX_BREAK) state <= ST_EXT_BREAK;
            else if (rx_data != PFX_EXT) state <= ST_IDLE;
          end
          default: begin
            if (!isPfx) state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        // abandon a prefix whose follow-up byte never arrived
        if (toCnt == TO_LAST) begin
          state <= ST_IDLE;
          toCnt <= '0;
        end else begin
          toCnt <= toCnt + 1'b1;
        end
      end
    end
  end

  ps2_evt_fifo #(
    .W     (KW + 1),
    .DEPTH (EVT_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .clear    (clear),
    .push     (push),
    .pushData ({idx[KW-1:0], !isBrk}),
    .pop      (pop),
    .headData (head),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  assign evt_valid = !fifoEmpty;
  assign evt_key = fifoEmpty ? '0 : head[KW:1];
  assign evt_pressed = !fifoEmpty && head[0];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: make/break, repeat, unknown
// codes, overflow, prefix timeout, clear and mid-sequence reset.
module tb_ps2_key_tracker;

  localparam int NK = 30;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rxData = 8'h00;
  logic          rxValid = 1'b0;
  logic          clr = 1'b0;
  logic [NK-1:0] keyState;
  logic          evtValid;
  logic [4:0]    evtKey;
  logic          evtPressed;
  logic          evtReady = 1'b0;
  logic          evtOverflow;
  logic          unknownCode;

  int nTests = 0;
  int nFail = 0;

  always #10 clk = ~clk;

  ps2_key_tracker #(
    .NUM_KEYS       (NK),
    .EVT_DEPTH      (8),
    .PREFIX_TIMEOUT (TO)
  ) dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .rx_data      (rxData),
    .rx_valid     (rxValid),
    .clear        (clr),
    .key_state    (keyState),
    .evt_valid    (evtValid),
    .evt_key      (evtKey),
    .evt_pressed  (evtPressed),
    .evt_ready    (evtReady),
    .evt_overflow (evtOverflow),
    .unknown_code (unknownCode)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rxData = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic popCheck(input string tag, input int key,
                          input logic pressed);
    check({tag, "_v"}, 32'(evtValid), 32'd1);
    check({tag, "_k"}, 32'(evtKey), 32'(key));
    check({tag, "_p"}, 32'(evtPressed), 32'(pressed));
    evtReady = 1'b1;
    @(negedge clk);
    evtReady = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [7:0] codes [9];

  initial begin
    codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
              8'h2E, 8'h36, 8'h3D, 8'h3E};

    repeat (2) @(negedge clk);
    check("rst_ks", 32'(keyState), 32'd0);
    check("rst_ev", 32'(evtValid), 32'd0);
    check("rst_ek", 32'(evtKey), 32'd0);
    check("rst_ep", 32'(evtPressed), 32'd0);
    check("rst_of", 32'(evtOverflow), 32'd0);
    check("rst_uk", 32'(unknownCode), 32'd0);
    resetn = 1'b1;

    // space press/release with consumer always ready
    evtReady = 1'b1;
    sendByte(8'h29);
    check("sp_ks1", 32'(keyState[28]), 32'd1);
    check("sp_v1", 32'(evtValid), 32'd1);
    check("sp_k1", 32'(evtKey), 32'd28);
    check("sp_p1", 32'(evtPressed), 32'd1);
    sendByte(8'hF0);
    check("sp_ks_f0", 32'(keyState[28]), 32'd1);
    sendByte(8'h29);
    check("sp_ks2", 32'(keyState[28]), 32'd0);
    check("sp_v2", 32'(evtValid), 32'd1);
    check("sp_k2", 32'(evtKey), 32'd28);
    check("sp_p2", 32'(evtPressed), 32'd0);
    @(negedge clk);
    check("sp_empty", 32'(evtValid), 32'd0);
    evtReady = 1'b0;

    // typematic repeat yields one press
    sendByte(8'h15);
    sendByte(8'h15);
    sendByte(8'h15);
    sendByte(8'h1D);
    check("rep_ks", 32'(keyState), 32'h0001_8000);
    popCheck("rep_e0", 15, 1'b1);
    popCheck("rep_e1", 16, 1'b1);
    check("rep_empty", 32'(evtValid), 32'd0);

    // extended codes are unmapped
    sendByte(8'hE0);
    check("ext_nouk", 32'(unknownCode), 32'd0);
    sendByte(8'h75);
    check("ext_uk1", 32'(unknownCode), 32'd1);
    @(negedge clk);
    check("ext_uk1_end", 32'(unknownCode), 32'd0);
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h75);
    check("ext_uk2", 32'(unknownCode), 32'd1);
    check("ext_noev", 32'(evtValid), 32'd0);
    sendByte(8'h0E);
    check("ext_uk3", 32'(unknownCode), 32'd0);
    popCheck("tilde", 10, 1'b1);

    // start from a clean slate for the overflow run
    pulseClear();
    check("clr_ks", 32'(keyState), 32'd0);

    for (int k = 0; k < 9; k++) begin
      sendByte(codes[k]);
      sendByte(8'hF0);
      sendByte(codes[k]);
    end
    check("of_flag", 32'(evtOverflow), 32'd1);
    check("of_ks", 32'(keyState), 32'd0);
    for (int e = 0; e < 8; e++) popCheck("of_drain", e / 2, (e % 2) == 0);
    check("of_empty", 32'(evtValid), 32'd0);
    check("of_sticky", 32'(evtOverflow), 32'd1);

    // full FIFO with push and pop together: no drop
    pulseClear();
    for (int k = 0; k < 8; k++) sendByte(codes[k]);
    @(negedge clk);
    evtReady = 1'b1;
    rxData = codes[8];
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    evtReady = 1'b0;
    check("pp_of", 32'(evtOverflow), 32'd0);
    check("pp_ks8", 32'(keyState[8]), 32'd1);
    for (int e = 1; e < 9; e++) popCheck("pp_drain", e, 1'b1);
    check("pp_empty", 32'(evtValid), 32'd0);

    // leave overflow set to watch clear drop it later
    pulseClear();
    for (int k = 0; k < 9; k++) sendByte(codes[k]);
    check("of2_flag", 32'(evtOverflow), 32'd1);
    for (int e = 0; e < 8; e++) popCheck("of2_drain", e, 1'b1);
    sendByte(8'hF0);
    for (int k = 0; k < 9; k++) sendByte(codes[k]);
    pulseClear();
    check("of2_clr", 32'(keyState), 32'd0);
    check("of2_clr_of", 32'(evtOverflow), 32'd0);

    // make overflow sticky again, then use a stale F0 prefix
    for (int k = 0; k < 9; k++) sendByte(codes[k]);
    for (int e = 0; e < 8; e++) popCheck("to_pre", e, 1'b1);
    check("to_of", 32'(evtOverflow), 32'd1);
    sendByte(8'hF0);
    sendByte(8'h16);
    check("to_ref_rel", 32'(keyState[1]), 32'd0);
    popCheck("to_ref_ev", 1, 1'b0);
    pulseClear();
    sendByte(8'hF0);
    repeat (TO + 5) @(negedge clk);
    sendByte(8'h16);
    check("to_ks", 32'(keyState[1]), 32'd1);
    check("to_k", 32'(evtKey), 32'd1);
    check("to_p", 32'(evtPressed), 32'd1);
    sendByte(8'h29);
    check("to_of2", 32'(evtOverflow), 32'd0);
    pulseClear();
    check("to_clr_ks", 32'(keyState), 32'd0);
    check("to_clr_ev", 32'(evtValid), 32'd0);

    // clear and a byte in the same cycle: byte lost
    @(negedge clk);
    rxData = 8'h29;
    rxValid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    clr = 1'b0;
    check("cb_ks", 32'(keyState), 32'd0);
    check("cb_ev", 32'(evtValid), 32'd0);

    // reset after F0 while Q held
    sendByte(8'h15);
    sendByte(8'hF0);
    resetn = 1'b0;
    #1;
    check("mr_ks", 32'(keyState), 32'd0);
    check("mr_ev", 32'(evtValid), 32'd0);
    check("mr_ek", 32'(evtKey), 32'd0);
    check("mr_ep", 32'(evtPressed), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sendByte(8'h15);
    check("mr_ks15", 32'(keyState[15]), 32'd1);
    popCheck("mr_evt", 15, 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 set-2 scan-code decoder and key-state tracker. Sits between the PS2_Controller receive port and the master FSM / note logic. Replaces the inline per-byte key capture with a proper make/break/extended prefix state machine, per-key held state, and a buffered press/release event stream with handshake.

## Interface
Parameters:
- NUM_KEYS, 30, number of tracked keys; indices 0..NUM_KEYS-1 per shared key map
- EVT_DEPTH, 8, event FIFO depth; power of two, ≥2
- PREFIX_TIMEOUT, 50000, cycles a prefix state may wait for its next byte before abandoning it

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  reset, asynchronous, active-low
- rx_data  in  8  byte from PS2_Controller
- rx_valid  in  1  one-cycle strobe, rx_data valid
- clear  in  1  synchronous flush: held state, FIFO, overflow, FSM
- key_state  out  NUM_KEYS  bit i = key i currently held
- evt_valid  out  1  FIFO non-empty
- evt_key  out  clog2(NUM_KEYS)  key index of head event
- evt_pressed  out  1  1 = press, 0 = release (head event)
- evt_ready  in  1  consumer pops head when evt_valid && evt_ready
- evt_overflow  out  1  sticky: an event was dropped
- unknown_code  out  1  one-cycle pulse: unmapped code consumed

## Operation
- Decoder FSM states: IDLE, BREAK (F0 seen), EXT (E0 seen), EXT_BREAK (E0 F0 seen). Transitions only on rx_valid.
- IDLE: F0→BREAK; E0→EXT; 0xAA/0xFA/0xFE/0xEE/0x00/0xFF ignored, stay IDLE; else make code → lookup, IDLE.
- BREAK: E0→EXT; F0 stays; other → break code lookup, IDLE.
- EXT: F0→EXT_BREAK; E0 stays; other → extended make lookup, IDLE.
- EXT_BREAK: E0/F0 stay; other → extended break lookup, IDLE.
- Lookup (code, ext) → index or NONE. NONE: pulse unknown_code, no state change. All extended codes map NONE in default map.
- Make on key not held: set key_state bit, push press event. Make on held key (typematic repeat): no change, no event.
- Break on held key: clear bit, push release event. Break on key not held: no change, no event.
- Multiple keys held simultaneously are independent; a break affects only its own key.
- Prefix timeout: counter runs in BREAK/EXT/EXT_BREAK, reloads on every rx_valid; reaching PREFIX_TIMEOUT returns FSM to IDLE, no other effect.
- FIFO full and push with no pop same cycle: event dropped, evt_overflow set. Full with push and pop same cycle: both performed, no overflow.
- clear: key_state←0, FIFO emptied, evt_overflow←0, FSM←IDLE, timeout counter←0; no release events generated. clear with rx_valid same cycle: clear wins, byte discarded.

## Timing
- Reset values: key_state 0, evt_valid 0, evt_key 0, evt_pressed 0, evt_overflow 0, unknown_code 0, FSM IDLE.
- rx_valid sampled at edge N: key_state, FIFO write, unknown_code all visible after edge N (1-cycle latency).
- Empty FIFO: evt_valid rises same cycle key_state changes; evt_key/evt_pressed valid whenever evt_valid high, stable until popped.
- Pop at edge M: next entry (or evt_valid=0) visible after M.
- Back-to-back rx_valid every cycle supported; no internal stall, no ready toward PS2_Controller.
- Reset asserted mid-sequence (e.g. after F0): everything returns to reset values immediately; following byte treated as from IDLE.

## Structure
- Shared package ps2_keys_pkg: key index constants (KEY_0=0 … KEY_9=9, KEY_TILDE=10, KEY_MINUS=11, KEY_EQUALS=12, KEY_BACKSPACE=13, KEY_TAB=14, KEY_Q=15 … KEY_P=24, KEY_LBRACKET=25, KEY_RBRACKET=26, KEY_BACKSLASH=27, KEY_SPACE=28, KEY_ENTER=29), KEY_NONE, prefix constants 0xF0/0xE0, decoder state enum, lookup function (code, ext) → index.
- One sub-module: ps2_evt_fifo (synchronous FIFO, width clog2(NUM_KEYS)+1, depth EVT_DEPTH, show-ahead, full/empty, simultaneous push/pop).

## Test plan
- Bytes 0x29 then F0 0x29 → key_state[28] 1 then 0; events (28,press),(28,release); evt_ready held 1 → FIFO empty after.
- 0x15 0x15 0x15 (repeat) then 0x1D → one press for 15, one for 16; key_state bits 15,16 both 1.
- E0 0x75, E0 F0 0x75, then 0x0E → two unknown_code pulses, no events, then (10,press).
- evt_ready=0, press/release 9 distinct keys (18 events, EVT_DEPTH=8) → 8 events retained, evt_overflow=1; drain yields first 8 in order.
- F0 then idle PREFIX_TIMEOUT cycles, then 0x16 → (1,press), not release; clear after → key_state 0, evt_valid 0, evt_overflow 0.
- resetn low one cycle after F0 while key 15 held → all outputs 0; next 0x15 → (15,press).
